linear_layer: RTL and testbench

LINEAR_LAYER -- requirements
Module: linear_layer

---
 rtl/griffin_pkg.sv | 39 +++
 rtl/galois_add_three.sv | 31 +++
 rtl/linear_layer.sv | 132 +++++++++++++
 tb/tb_linear_layer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/griffin_pkg.sv
// Shared Griffin permutation constants: BN254 scalar field, state geometry,
// linear-layer FSM encoding and the per-round additive constant table.
package griffin_pkg;

    localparam int N_BITS     = 254;
    localparam int STATE_SIZE = 3;
    localparam int N_ROUNDS   = 14;
    localparam int ROUND_W    = 4;

    localparam logic [N_BITS-1:0] PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } ll_state_t;

    // Every entry is already reduced below PRIME_MODULUS; a few sit right at
    // the top of the field so the modular wrap gets exercised.
    localparam logic [N_BITS-1:0] ROUND_CONSTANTS [N_ROUNDS][STATE_SIZE] = '{
        '{254'd5, 254'h1f2e3d4c5b6a79881726354453627180, PRIME_MODULUS - 254'd2},
        '{254'h2a4f0c9e81d37b5566e2190f3ac8d41b7e29c0a5d6f3812b4c97e05a1d8f6c3e, 254'd0, 254'h0123456789abcdef},
        '{254'h15d2c8e7a1b3f4096e8d7c6b5a49382716f5e4d3c2b1a09f8e7d6c5b4a392817, 254'd17, 254'h0000ffff0000ffff0000ffff0000ffff},
        '{PRIME_MODULUS - 254'd1, 254'h2e0b9c7d5f3a1e8c6b4d2f0a9e7c5b3d1f8a6c4e2b0d9f7a5c3e1b8d6f4a2c0e, 254'd99},
        '{254'h09a8b7c6d5e4f3021fedcba987654321, 254'h1c4e6a8b0d2f4163857a9cbedf102435, 254'h2468ace02468ace02468ace02468ace0},
        '{PRIME_MODULUS - 254'd1, PRIME_MODULUS - 254'd3, 254'd4},
        '{254'h1111111111111111111111111111111111111111111111111111111111111111, 254'd1, 254'h0abcdef},
        '{254'h0fedcba9876543210fedcba9876543210fedcba9876543210fedcba987654321, 254'h2d1c0b9a88776655443322110ffeeddccbbaa998877665544332211000ffeedd, 254'd7},
        '{254'd3, 254'h0102030405060708090a0b0c0d0e0f10, PRIME_MODULUS - 254'd100},
        '{254'h27a3b1c9d5e7f2046813579bdf02468ace13579bdf02468ace13579bdf024681, 254'h00c0ffee, 254'h1badcafe},
        '{254'h0deadbeef, 254'h2222222222222222222222222222222222222222222222222222222222222222, 254'd0},
        '{254'h1357924680, PRIME_MODULUS - 254'd5, 254'h2f00000000000000000000000000000000000000000000000000000000000001},
        '{254'h0a0a0a0a0a0a0a0a0a0a0a0a0a0a0a0a, 254'h05050505050505050505050505050505, 254'h1234},
        '{254'h18f3e2d1c0b0a09080706050403020100f0e0d0c0b0a09080706050403020100, 254'd42, PRIME_MODULUS - 254'd42}
    };

endpackage

// File: rtl/galois_add_three.sv
// Three-operand modular adder: operands are field elements (< p), result is
// (a + b + c) mod p using a single N_BITS+2 wide sum and at most one correction.
module galois_add_three #(
    parameter int                N_BITS        = griffin_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = griffin_pkg::PRIME_MODULUS
) (
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic [N_BITS-1:0] i_c,
    output logic [N_BITS-1:0] o_sum
);

    logic [N_BITS+1:0] w_p;
    logic [N_BITS+1:0] w_2p;
    logic [N_BITS+1:0] w_sum;

    assign w_p   = {2'b00, PRIME_MODULUS};
    assign w_2p  = {1'b0, PRIME_MODULUS, 1'b0};
    assign w_sum = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c};

    // Sum of three reduced operands is below 3p, so subtracting 0, p or 2p suffices.
    always_comb begin
        o_sum = w_sum[N_BITS-1:0];
        if (w_sum >= w_2p) begin
            o_sum = N_BITS'(w_sum - w_2p);
        end else if (w_sum >= w_p) begin
            o_sum = N_BITS'(w_sum - w_p);
        end
    end

endmodule

// File: rtl/linear_layer.sv
// Griffin linear layer: out[i] = x[i] + sum(x) + RC[round][i] mod p, computed
// serially through one shared three-operand modular adder.
//
//   state | meaning
//   IDLE  | waiting for enable; captures inState/round_idx on start
//   SUM   | registers S = x0 + x1 + x2 mod p
//   MIX   | writes one outState word per cycle, index 0..STATE_SIZE-1
//   DONE  | one-cycle completion pulse, round_err valid
module linear_layer #(
    parameter int                N_BITS        = griffin_pkg::N_BITS,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = griffin_pkg::PRIME_MODULUS,
    parameter int                STATE_SIZE    = griffin_pkg::STATE_SIZE,
    parameter int                N_ROUNDS      = griffin_pkg::N_ROUNDS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [3:0]                   round_idx,
    input  logic [N_BITS*STATE_SIZE-1:0] inState,
    output logic [N_BITS*STATE_SIZE-1:0] outState,
    output logic                         busy,
    output logic                         done,
    output logic                         round_err
);

    import griffin_pkg::*;

    localparam int                IDX_W    = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STATE_SIZE - 1);

    ll_state_t         r_state;
    ll_state_t         w_next;
    logic [N_BITS-1:0] r_in  [STATE_SIZE];
    logic [N_BITS-1:0] r_out [STATE_SIZE];
    logic [3:0]        r_round;
    logic [N_BITS-1:0] r_s;
    logic [IDX_W-1:0]  r_idx;
    logic              w_round_ok;
    logic              w_capture;
    logic [N_BITS-1:0] w_rc;
    logic [N_BITS-1:0] w_add_a;
    logic [N_BITS-1:0] w_add_b;
    logic [N_BITS-1:0] w_add_c;
    logic [N_BITS-1:0] w_add_sum;

    assign w_capture  = (r_state == IDLE) && enable;
    assign w_round_ok = (r_round < 4'(N_ROUNDS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_next = SUM;
            SUM:     w_next = MIX;
            MIX:     if (r_idx == LAST_IDX) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_rc = '0;
        if (w_round_ok) begin
            w_rc = ROUND_CONSTANTS[r_round][r_idx];
        end
    end

    // SUM folds all three captured words; MIX adds word, S and constant.
    always_comb begin
        w_add_a = r_in[r_idx];
        w_add_b = r_s;
        w_add_c = w_rc;
        if (r_state == SUM) begin
            w_add_a = r_in[0];
            w_add_b = r_in[1];
            w_add_c = r_in[2];
        end
    end

    galois_add_three #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_add (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_c   (w_add_c),
        .o_sum (w_add_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STATE_SIZE; k++) begin
                r_in[k]  <= '0;
                r_out[k] <= '0;
            end
            r_round <= '0;
            r_s     <= '0;
            r_idx   <= '0;
        end else begin
            if (w_capture) begin
                for (int k = 0; k < STATE_SIZE; k++) begin
                    r_in[k] <= inState[k*N_BITS +: N_BITS];
                end
                r_round <= round_idx;
                r_idx   <= '0;
            end
            if (r_state == SUM) begin
                r_s <= w_add_sum;
            end
            if (r_state == MIX) begin
                r_out[r_idx] <= w_add_sum;
                r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < STATE_SIZE; g++) begin : g_out
        assign outState[g*N_BITS +: N_BITS] = r_out[g];
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign round_err = (r_state == DONE) && !w_round_ok;

endmodule

// File: tb/tb_linear_layer.sv
// Randomized self-checking bench for linear_layer against a wide-arithmetic
// field model of out[i] = (x[i] + sum(x) + RC[r][i]) mod p.
module tb_linear_layer;

    import griffin_pkg::*;

    localparam int NB = N_BITS;
    localparam int SS = STATE_SIZE;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [3:0]        round_idx;
    logic [NB*SS-1:0]  inState;
    logic [NB*SS-1:0]  outState;
    logic              busy;
    logic              done;
    logic              round_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    linear_layer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .round_idx (round_idx),
        .inState   (inState),
        .outState  (outState),
        .busy      (busy),
        .done      (done),
        .round_err (round_err)
    );

    function automatic logic [NB-1:0] rand_fe();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        v = v % {2'b00, PRIME_MODULUS};
        return v[NB-1:0];
    endfunction

    function automatic logic [NB*SS-1:0] rand_state();
        logic [NB*SS-1:0] st;
        for (int k = 0; k < SS; k++) st[k*NB +: NB] = rand_fe();
        return st;
    endfunction

    function automatic logic [NB-1:0] expect_word(input logic [NB*SS-1:0] st, input int i, input int rnd);
        logic [NB+7:0] p, s, rc, t;
        p = {8'd0, PRIME_MODULUS};
        s = '0;
        for (int k = 0; k < SS; k++) s = s + {8'd0, st[k*NB +: NB]};
        s = s % p;
        rc = '0;
        if (rnd < N_ROUNDS) rc = {8'd0, ROUND_CONSTANTS[rnd][i]};
        t = ({8'd0, st[i*NB +: NB]} + s + rc) % p;
        return t[NB-1:0];
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the capture edge.
    task automatic launch(input logic [NB*SS-1:0] st, input logic [3:0] rnd);
        inState   = st;
        round_idx = rnd;
        enable    = 1'b1;
        @(posedge clk); #1;
        enable    = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit early_err);
        lat = 0;
        early_err = 1'b0;
        while (!done && lat < 20) begin
            if (round_err) early_err = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; round_idx = 4'd0; inState = rand_state();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (round_err !== 1'b0) begin errors++; $display("FAIL reset_round_err got %b want 0", round_err); end
        checks++; if (outState !== '0) begin errors++; $display("FAIL reset_out got %h want 0", outState); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_capture got busy %b want 0", busy); end
        enable = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_and_check(input string name, input logic [NB*SS-1:0] st, input int rnd);
        int lat; bit early;
        logic [NB-1:0] exp_w;
        launch(st, 4'(rnd));
        wait_done(lat, early);
        checks++; if (lat != 4 || done !== 1'b1) begin errors++; $display("FAIL %s_latency got %0d want 4", name, lat); end
        for (int i = 0; i < SS; i++) begin
            exp_w = expect_word(st, i, rnd);
            checks++;
            if (outState[i*NB +: NB] !== exp_w) begin
                errors++; $display("FAIL %s_word%0d got %h want %h", name, i, outState[i*NB +: NB], exp_w);
            end
        end
        checks++; if (round_err !== (rnd >= N_ROUNDS)) begin errors++; $display("FAIL %s_round_err got %b want %b", name, round_err, rnd >= N_ROUNDS); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL %s_round_err_early got %b want 0", name, early); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || round_err !== 1'b0) begin
            errors++; $display("FAIL %s_idle got busy %b done %b err %b want 0 0 0", name, busy, done, round_err);
        end
    endtask

    task automatic test_basic();
        logic [NB*SS-1:0] st;
        logic [NB+7:0] hand;
        st = {254'd3, 254'd2, 254'd1};
        run_and_check("basic", st, 0);
        hand = ({8'd0, 254'd7} + {8'd0, ROUND_CONSTANTS[0][0]}) % {8'd0, PRIME_MODULUS};
        checks++; if (outState[NB-1:0] !== hand[NB-1:0]) begin errors++; $display("FAIL basic_hand0 got %h want %h", outState[NB-1:0], hand[NB-1:0]); end
    endtask

    task automatic test_max();
        logic [NB*SS-1:0] st;
        logic [NB-1:0] pm1;
        pm1 = PRIME_MODULUS - 254'd1;
        st = {pm1, pm1, pm1};
        run_and_check("max", st, 5);
        for (int i = 0; i < SS; i++) begin
            checks++;
            if (outState[i*NB +: NB] >= PRIME_MODULUS) begin errors++; $display("FAIL max_range%0d got %h want below p", i, outState[i*NB +: NB]); end
        end
    endtask

    task automatic test_bad_round();
        run_and_check("badround", rand_state(), 15);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) run_and_check("random", rand_state(), int'($urandom_range(0, 15)));
    endtask

    task automatic test_busy_ignore();
        logic [NB*SS-1:0] st;
        logic [NB-1:0] seen [SS];
        int ndone, done_at, rnd;
        st = rand_state(); rnd = int'($urandom_range(0, 13));
        ndone = 0; done_at = -1;
        launch(st, 4'(rnd));
        for (int c = 0; c < 12; c++) begin
            if (c < 5) begin
                enable = (c % 2 == 0); inState = rand_state(); round_idx = 4'($urandom_range(0, 15));
            end else begin
                enable = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c;
                    for (int i = 0; i < SS; i++) seen[i] = outState[i*NB +: NB];
                end
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL busy_single_done got %0d want 1", ndone); end
        checks++; if (done_at != 3) begin errors++; $display("FAIL busy_done_time got %0d want 3", done_at); end
        for (int i = 0; i < SS; i++) begin
            checks++;
            if (seen[i] !== expect_word(st, i, rnd)) begin errors++; $display("FAIL busy_word%0d got %h want %h", i, seen[i], expect_word(st, i, rnd)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [NB*SS-1:0] st;
        int rnd, ndone;
        st = rand_state(); rnd = int'($urandom_range(0, 13));
        launch(st, 4'(rnd));
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (outState[NB-1:0] !== expect_word(st, 0, rnd)) begin
            errors++; $display("FAIL mid_word0 got %h want %h", outState[NB-1:0], expect_word(st, 0, rnd));
        end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (outState !== '0) begin errors++; $display("FAIL mid_reset_out got %h want 0", outState); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || round_err !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags got busy %b done %b err %b want 0 0 0", busy, done, round_err);
        end
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        ndone = 0;
        repeat (6) begin @(posedge clk); #1; if (done || busy) ndone++; end
        checks++; if (ndone != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", ndone); end
        run_and_check("after_reset", rand_state(), int'($urandom_range(0, 15)));
    endtask

    task automatic test_back_to_back();
        logic [NB*SS-1:0] st;
        int rnd, pulses, last, prev_done, guard;
        st = rand_state(); rnd = int'($urandom_range(0, 13));
        inState = st; round_idx = 4'(rnd); enable = 1'b1;
        pulses = 0; last = -1; prev_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                checks++; if (prev_done != 0) begin errors++; $display("FAIL b2b_width got 2 cycles at %0d want 1", c); end
                if (last >= 0) begin
                    checks++; if (c - last != SS + 3) begin errors++; $display("FAIL b2b_interval got %0d want %0d", c - last, SS + 3); end
                end
                checks++; if (outState[(SS-1)*NB +: NB] !== expect_word(st, SS-1, rnd)) begin
                    errors++; $display("FAIL b2b_word got %h want %h", outState[(SS-1)*NB +: NB], expect_word(st, SS-1, rnd));
                end
                last = c; pulses++;
            end
            prev_done = done;
        end
        checks++; if (pulses != 6) begin errors++; $display("FAIL b2b_pulses got %0d want 6", pulses); end
        enable = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin @(posedge clk); #1; guard++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_bad_round();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
